fc_mac_share_arbiter: RTL

- Round-robin scheduler that time-shares one saturating mac instance (WIDTH-bit, 3-stage, sync clear) between two FC row-job requesters, e.g. two fc layer datapaths.
- Arbitrates job starts, clears the MAC, forwards the winner's operand stream, and waits out the pipeline drain.
- Optionally applies ReLU, then parks each row result in a per-requester output register with a valid/ready handshake.

---
 rtl/fc_mac_share_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fc_mac_share_arbiter.sv
// fc_mac_share_arbiter: round-robin time-sharing of one pipelined saturating MAC
// between two FC row-job requesters, with optional ReLU and per-requester result registers.
module fc_mac_share_arbiter #(
   parameter int         WIDTH   = 16,
   parameter int         LEN_W   = 6,
   parameter int         MAC_LAT = 3,
   parameter logic [1:0] RELU    = 2'b00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [LEN_W-1:0] req_len0,
   input  logic [LEN_W-1:0] req_len1,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] op_a0,
   input  logic [WIDTH-1:0] op_b0,
   input  logic [WIDTH-1:0] op_a1,
   input  logic [WIDTH-1:0] op_b1,
   input  logic [1:0]       op_valid,
   output logic [1:0]       op_ready,
   output logic             mac_clr,
   output logic [WIDTH-1:0] mac_a,
   output logic [WIDTH-1:0] mac_b,
   output logic             mac_valid_in,
   input  logic [WIDTH-1:0] mac_f,
   output logic [WIDTH-1:0] res_data0,
   output logic [WIDTH-1:0] res_data1,
   output logic [1:0]       res_valid,
   input  logic [1:0]       res_ready,
   output logic             busy
);
   localparam int DW = $clog2(MAC_LAT + 1);
   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;
   state_t           state_q, state_d;
   logic             owner_q, owner_d, last_q, last_d, grant, cap;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [1:0]       elig, res_valid_q, own_oh;
   logic [WIDTH-1:0] res_q [2];
   logic [WIDTH-1:0] result;
   // A requester still holding an unread result must not overwrite it.
   assign elig   = req_valid & ~res_valid_q;
   assign grant  = (&elig) ? ~last_q : elig[1];
   assign own_oh = owner_q ? 2'b10 : 2'b01;
   assign result = (RELU[owner_q] && mac_f[WIDTH-1]) ? '0 : mac_f;
   assign op_ready     = (!reset && state_q == STREAM && rem_q != '0) ? own_oh : 2'b00;
   assign mac_valid_in = |(op_valid & op_ready);
   assign mac_a   = (state_q == STREAM) ? (owner_q ? op_a1 : op_a0) : '0;
   assign mac_b   = (state_q == STREAM) ? (owner_q ? op_b1 : op_b0) : '0;
   assign mac_clr = reset | (state_q == CLEAR);
   assign busy    = state_q != IDLE;
   assign res_valid = res_valid_q;
   assign res_data0 = res_q[0];
   assign res_data1 = res_q[1];
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      rem_d     = rem_q;
      drain_d   = drain_q;
      cap       = 1'b0;
      req_ready = 2'b00;
      case (state_q)
         IDLE: if (|elig) begin
            owner_d   = grant;
            last_d    = grant;
            rem_d     = grant ? req_len1 : req_len0;
            req_ready = grant ? 2'b10 : 2'b01;
            state_d   = CLEAR;
         end
         CLEAR: begin
            drain_d = DW'(MAC_LAT - 1);
            state_d = (rem_q != '0) ? STREAM : DRAIN;
         end
         STREAM: if (mac_valid_in) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
               drain_d = DW'(MAC_LAT - 1);
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            drain_d = drain_q - DW'(1);
            if (drain_q == '0) begin
               cap     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (reset) req_ready = 2'b00;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         rem_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         rem_q   <= rem_d;
         drain_q <= drain_d;
      end
   end
   // Capture takes priority over a same-edge consume of the same register.
   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++) begin
         if (reset) begin
            res_valid_q[r] <= 1'b0;
            res_q[r]       <= '0;
         end else if (cap && owner_q == 1'(r)) begin
            res_valid_q[r] <= 1'b1;
            res_q[r]       <= result;
         end else if (res_ready[r]) begin
            res_valid_q[r] <= 1'b0;
         end
      end
   end
endmodule
